// File: rtl/wb_scoreboard.sv
// wb_scoreboard: tracks in-flight register writes, stalls decode on RAW/WAW/capacity hazards, registers the writeback bus
module wb_scoreboard #(
    parameter int MAX_INFLIGHT = 4,
    localparam int CW = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_valid,
    input  logic [4:0]    issue_rs1,
    input  logic [4:0]    issue_rs2,
    input  logic          issue_uses_rs1,
    input  logic          issue_uses_rs2,
    input  logic          issue_writes,
    input  logic [4:0]    issue_rd,
    output logic          issue_stall,
    input  logic          wb_valid,
    input  logic [4:0]    wb_rd,
    input  logic [31:0]   wb_value,
    output logic          rd_write_en,
    output logic [4:0]    rd_write_back,
    output logic [31:0]   rd_value,
    output logic [31:0]   busy_mask,
    output logic [CW-1:0] inflight_count,
    output logic          wb_error
);
    logic [31:0]   busy;
    logic [CW-1:0] count;
    logic          h1, h2, h3, h4, do_set, do_clr, bad_wb;
    logic [31:0]   set_mask, clr_mask;

    assign busy_mask      = busy;
    assign inflight_count = count;

    // Hazard detection from current state only; a writeback sampled this cycle does not bypass
    always_comb begin
        h1          = issue_uses_rs1 && issue_rs1 != 5'd0 && busy[issue_rs1];
        h2          = issue_uses_rs2 && issue_rs2 != 5'd0 && busy[issue_rs2];
        h3          = issue_writes && issue_rd != 5'd0 && busy[issue_rd];
        h4          = issue_writes && issue_rd != 5'd0 && count == CW'(MAX_INFLIGHT);
        issue_stall = issue_valid && (h1 || h2 || h3 || h4);
        do_set      = issue_valid && !issue_stall && issue_writes && issue_rd != 5'd0;
        do_clr      = wb_valid && wb_rd != 5'd0 && busy[wb_rd];
        bad_wb      = wb_valid && wb_rd != 5'd0 && !busy[wb_rd];
        set_mask    = do_set ? (32'd1 << issue_rd) : 32'd0;
        clr_mask    = do_clr ? (32'd1 << wb_rd) : 32'd0;
    end

    // Busy mask, in-flight count and sticky error; set and clear never hit the same register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 32'd0;
            count    <= '0;
            wb_error <= 1'b0;
        end else begin
            busy     <= (busy | set_mask) & ~clr_mask & 32'hFFFF_FFFE;
            count    <= (do_set && !do_clr) ? count + CW'(1) :
                        (do_clr && !do_set) ? count - CW'(1) : count;
            wb_error <= wb_error | bad_wb;
        end
    end

    // Writeback bus is zeroed when idle or targeting x0 so enable-less forwarding of x0 yields 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_write_en   <= 1'b0;
            rd_write_back <= 5'd0;
            rd_value      <= 32'd0;
        end else begin
            rd_write_en   <= wb_valid;
            rd_write_back <= wb_valid ? wb_rd : 5'd0;
            rd_value      <= (wb_valid && wb_rd != 5'd0) ? wb_value : 32'd0;
        end
    end
endmodule

// File: tb/tb_wb_scoreboard.sv
// tb_wb_scoreboard: directed scoreboard bench for wb_scoreboard
module tb_wb_scoreboard;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid = 1'b0, issue_uses_rs1 = 1'b0, issue_uses_rs2 = 1'b0, issue_writes = 1'b0;
    logic [4:0]  issue_rs1 = '0, issue_rs2 = '0, issue_rd = '0, wb_rd = '0;
    logic        wb_valid = 1'b0;
    logic [31:0] wb_value = '0;
    logic        issue_stall, rd_write_en, wb_error;
    logic [4:0]  rd_write_back;
    logic [31:0] rd_value, busy_mask;
    logic [2:0]  inflight_count;

    int errors = 0;
    int checks = 0;
    logic [36:0] exp_q[$];

    wb_scoreboard #(.MAX_INFLIGHT(4)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_uses_rs1(issue_uses_rs1), .issue_uses_rs2(issue_uses_rs2),
        .issue_writes(issue_writes), .issue_rd(issue_rd), .issue_stall(issue_stall),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_value(wb_value),
        .rd_write_en(rd_write_en), .rd_write_back(rd_write_back), .rd_value(rd_value),
        .busy_mask(busy_mask), .inflight_count(inflight_count), .wb_error(wb_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; issue_uses_rs1 = 0; issue_uses_rs2 = 0; issue_writes = 0;
        issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
        wb_valid = 0; wb_rd = 0; wb_value = 0;
    endtask

    task automatic issue_wr(input logic [4:0] rd);
        issue_valid = 1; issue_writes = 1; issue_rd = rd;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] v);
        wb_valid = 1; wb_rd = rd; wb_value = v;
        exp_q.push_back({rd, (rd == 5'd0) ? 32'd0 : v});
    endtask

    // Monitor: every valid bus beat must match the oldest expected writeback
    always @(negedge clk) begin
        if (!rst && rd_write_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL bus_unexpected: rd=%0d value=0x%08h with nothing expected", rd_write_back, rd_value);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                if ({rd_write_back, rd_value} !== e) begin
                    errors++;
                    $display("FAIL bus_beat: got rd=%0d value=0x%08h expected rd=%0d value=0x%08h",
                             rd_write_back, rd_value, e[36:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: timeout");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("reset_busy", busy_mask, 0);
        chk("reset_count", 32'(inflight_count), 0);
        chk("reset_err", 32'(wb_error), 0);
        chk("reset_wben", 32'(rd_write_en), 0);
        // RAW stall across writeback
        issue_wr(5); #1;
        chk("first_issue_stall", 32'(issue_stall), 0);
        step();
        chk("busy_after_issue5", busy_mask, 32'h20);
        chk("count_after_issue5", 32'(inflight_count), 1);
        idle(); issue_valid = 1; issue_uses_rs1 = 1; issue_rs1 = 5; #1;
        chk("raw_stall", 32'(issue_stall), 1);
        wb(5, 32'hDEADBEEF); #1;
        chk("raw_stall_during_wb", 32'(issue_stall), 1);
        step();
        wb_valid = 0; wb_rd = 0; wb_value = 0; #1;
        chk("raw_released", 32'(issue_stall), 0);
        chk("raw_wben", 32'(rd_write_en), 1);
        chk("raw_busy_clear", busy_mask, 0);
        step();
        chk("bus_idle_en", 32'(rd_write_en), 0);
        chk("bus_idle_val", rd_value, 0);
        // x0 handling
        idle(); issue_wr(0); step();
        chk("x0_busy", busy_mask, 0);
        chk("x0_count", 32'(inflight_count), 0);
        idle(); issue_wr(1); step(); issue_wr(2); step(); issue_wr(3); step();
        chk("busy_123", busy_mask, 32'hE);
        idle(); issue_valid = 1; issue_uses_rs1 = 1; issue_uses_rs2 = 1; #1;
        chk("x0_src_no_stall", 32'(issue_stall), 0);
        idle(); wb(0, 32'h1234); step();
        idle(); #1;
        chk("x0_wb_err", 32'(wb_error), 0);
        chk("x0_wb_busy", busy_mask, 32'hE);
        // Capacity
        issue_wr(4); step();
        chk("cap_count4", 32'(inflight_count), 4);
        issue_wr(6); #1;
        chk("cap_stall", 32'(issue_stall), 1);
        wb(1, 32'h11); step();
        wb_valid = 0; wb_rd = 0; wb_value = 0; #1;
        chk("cap_count3", 32'(inflight_count), 3);
        chk("cap_busy", busy_mask, 32'h1C);
        chk("cap_accept", 32'(issue_stall), 0);
        step();
        chk("cap_busy6", busy_mask, 32'h5C);
        chk("cap_count4b", 32'(inflight_count), 4);
        // WAW and simultaneous set/clear
        idle(); wb(2, 32'h22); step();
        idle(); issue_wr(7); step();
        idle(); wb(4, 32'h44); step();
        idle(); #1;
        chk("waw_setup_busy", busy_mask, 32'hC8);
        chk("waw_setup_count", 32'(inflight_count), 3);
        issue_wr(7); #1;
        chk("waw_stall", 32'(issue_stall), 1);
        idle(); issue_valid = 1; issue_uses_rs2 = 1; issue_rs2 = 7; #1;
        chk("rs2_stall", 32'(issue_stall), 1);
        idle(); issue_wr(8); wb(3, 32'h33); #1;
        chk("sim_no_stall", 32'(issue_stall), 0);
        step();
        idle(); #1;
        chk("sim_busy", busy_mask, 32'h1C0);
        chk("sim_count", 32'(inflight_count), 3);
        // Spurious writeback sets sticky error
        wb(9, 32'h99); step();
        idle(); #1;
        chk("err_set", 32'(wb_error), 1);
        chk("err_rd", 32'(rd_write_back), 9);
        chk("err_count", 32'(inflight_count), 3);
        chk("err_busy", busy_mask, 32'h1C0);
        step();
        chk("err_sticky", 32'(wb_error), 1);
        // Asynchronous reset mid-operation
        wb(6, 32'h66); step();
        idle();
        @(negedge clk); #1;
        chk("pre_rst_wben", 32'(rd_write_en), 1);
        rst = 1; #1;
        chk("arst_busy", busy_mask, 0);
        chk("arst_count", 32'(inflight_count), 0);
        chk("arst_wben", 32'(rd_write_en), 0);
        chk("arst_val", rd_value, 0);
        chk("arst_err", 32'(wb_error), 0);
        step();
        rst = 0;
        step();
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_scoreboard.md
# wb_scoreboard

Writeback-side companion to the decode-stage RAW forwarding unit. Tracks which architectural registers have in-flight writes, stalls decode on RAW/WAW hazards that forwarding cannot cover, and registers the writeback bus. That bus (rd_write_back, rd_value) is what the forwarding unit and register file consume. Sits between the MEM/WB pipeline register and the decode stage.

## Interface
- MAX_INFLIGHT, 4: maximum outstanding register writes; legal range 1..31.
- CW, $clog2(MAX_INFLIGHT+1): width of inflight_count; derived, not overridden.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- issue_valid  in  1  decode presents an instruction this cycle.
- issue_rs1, issue_rs2  in  5 each  source register selects.
- issue_uses_rs1, issue_uses_rs2  in  1 each  the instruction actually reads that source.
- issue_writes  in  1  the instruction writes rd.
- issue_rd  in  5  destination register.
- issue_stall  out  1  combinational; decode must hold the instruction when high.
- wb_valid  in  1  the writeback stage completes a write this cycle.
- wb_rd  in  5  writeback destination.
- wb_value  in  32  writeback data.
- rd_write_en  out  1  registered writeback strobe.
- rd_write_back  out  5  registered writeback destination.
- rd_value  out  32  registered writeback data.
- busy_mask  out  32  bit i set means register xi has a pending write; bit 0 is always 0.
- inflight_count  out  CW  number of set bits in busy_mask.
- wb_error  out  1  sticky; set by a writeback to a nonzero register that is not busy.

## Operation
- An instruction is accepted when issue_valid && !issue_stall. The issuing stage owns the handshake; this block only observes it.
- issue_stall = issue_valid && (H1 || H2 || H3 || H4), where:
  - H1: issue_uses_rs1 && issue_rs1!=0 && busy[issue_rs1].
  - H2: issue_uses_rs2 && issue_rs2!=0 && busy[issue_rs2].
  - H3 (WAW): issue_writes && issue_rd!=0 && busy[issue_rd].
  - H4 (capacity): issue_writes && issue_rd!=0 && inflight_count==MAX_INFLIGHT.
- Accepted instruction with issue_writes && issue_rd!=0: set busy[issue_rd] at the next edge.
- wb_valid with wb_rd!=0 and busy[wb_rd]: clear busy[wb_rd] at the next edge.
- wb_valid with wb_rd!=0 and !busy[wb_rd]: set wb_error. Busy state is unchanged, and the bus is still driven.
- wb_valid with wb_rd==0: bus is driven with rd 0 and value 0. Busy state is unchanged and there is no error.
- Writeback bus, registered on every edge:
  - If wb_valid: rd_write_en=1, rd_write_back=wb_rd, rd_value=(wb_rd==0 ? 0 : wb_value).
  - Else: all three are 0. This keeps the enable-less forwarding comparison harmless: a read of x0 forwards 0.
- No same-cycle bypass. A source whose writeback is being sampled this cycle still stalls. On the next cycle busy is clear and the value appears on rd_write_back/rd_value for forwarding.
- inflight_count:
  - +1 on a set only.
  - -1 on a clear only.
  - Unchanged when both happen in the same cycle. A set and a clear on the same register in one cycle is impossible, because H3 forbids it.
- issue_rd==0 never sets busy and never counts toward capacity.

## Timing
- Reset (async assert, any cycle, including mid-stall):
  - busy_mask=0, inflight_count=0, wb_error=0.
  - rd_write_en=0, rd_write_back=0, rd_value=0.
  - issue_stall then follows its combinational equations using the cleared state.
- Issue→busy visible: 1 cycle. wb_valid→busy clear and bus valid: 1 cycle.
- Minimum stall for a dependent instruction issued the cycle after its producer: until the cycle after the producer's wb_valid.
- issue_stall has no register stage and depends only on current state and the issue_* inputs. It does not depend on wb_*.
- wb_error clears only on rst.

## Test plan
- Reset mid-operation: busy_mask=0x0000_0006, assert rst asynchronously → busy_mask=0, inflight_count=0, rd_write_en=0 immediately, without waiting for a clock edge.
- RAW stall: issue rd=5 (accepted); next cycle issue rs1=5 → issue_stall=1. Apply wb_valid, wb_rd=5, wb_value=0xDEADBEEF → stall persists that cycle. Next cycle: issue_stall=0, rd_write_back=5, rd_value=0xDEADBEEF, rd_write_en=1.
- x0 handling:
  - Issue rd=0 → busy_mask stays 0 and inflight_count stays 0.
  - Issue rs1=0 with busy_mask=0xFFFF_FFFE → no stall.
  - wb_rd=0, wb_value=0x1234 → rd_value=0, wb_error stays 0.
- Capacity: MAX_INFLIGHT=4, issue rd=1,2,3,4 → count=4. Issue rd=6 → stall. Same cycle wb_valid rd=1 → next cycle count=3 and rd=6 is accepted.
- WAW and simultaneous events: busy[7]=1, issue rd=7 → stall. Accepted issue rd=8 in the same cycle as wb rd=3 → count unchanged, busy_mask bit8 set and bit3 cleared.
- Error: wb_valid wb_rd=9 with busy[9]=0 → wb_error=1 next cycle and stays 1, rd_write_back=9; count is unchanged.
